conv_seq_ctrl: RTL

Frame-level sequencer for the 5x5 convolution filter datapath. Holds a 25-entry signed coefficient bank written by the host and, on `go`, primes the filter with `flt_start`. It then streams the coefficients over `flt_fc_valid` / `flt_fc`, counts `flt_out_valid` pulses until a full frame is produced, and reports `done`. A stall watchdog raises `err` and aborts the frame if the filter stops producing pixels.

---
 rtl/conv_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: frame sequencer for the 5x5 convolution filter.
// Primes the filter, streams the coefficient bank, counts output pixels and watches for stalls.
module conv_seq_ctrl #(
   parameter int NUM_COEF  = 25,
   parameter int PIXELS    = 16384,
   parameter int PRIME_CYC = 2,
   parameter int TIMEOUT   = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [4:0]  cfg_addr,
   input  logic [7:0]  cfg_data,
   input  logic        go,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [14:0] pix_count,
   output logic        flt_start,
   output logic        flt_fc_valid,
   output logic [7:0]  flt_fc,
   input  logic        flt_out_valid
);
   localparam logic [4:0]  LP_NC    = 5'(NUM_COEF);
   localparam logic [4:0]  LP_LAST  = 5'(NUM_COEF - 1);
   localparam logic [2:0]  LP_PLAST = 3'(PRIME_CYC - 1);
   localparam logic [14:0] LP_PIX   = 15'(PIXELS);
   localparam logic [15:0] LP_TO    = 16'(TIMEOUT);
   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;
   state_t      r_state, w_state_n;
   logic [7:0]  r_coef [NUM_COEF];
   logic [4:0]  r_idx, w_idx_n;
   logic [2:0]  r_prime, w_prime_n;
   logic [15:0] r_wdog, w_wdog_n;
   logic [14:0] r_pix, w_pix_n;
   logic        r_err, w_err_n;
   logic        r_busy, r_done, r_start, r_fcv;
   logic [7:0]  r_fc;
   logic        w_we;
   assign w_we = cfg_we && (r_state == S_IDLE) && (cfg_addr < LP_NC);
   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_prime_n = r_prime;
      w_wdog_n  = r_wdog;
      w_pix_n   = r_pix;
      w_err_n   = r_err;
      case (r_state)
         S_IDLE: if (go) begin
            w_state_n = S_PRIME;
            w_prime_n = '0;
            w_idx_n   = '0;
            w_wdog_n  = '0;
            w_pix_n   = '0;
            w_err_n   = 1'b0;
         end
         S_PRIME: begin
            w_state_n = (r_prime == LP_PLAST) ? S_LOAD : S_PRIME;
            w_prime_n = r_prime + 3'd1;
            w_idx_n   = '0;
         end
         S_LOAD: begin
            w_state_n = (r_idx == LP_LAST) ? S_RUN : S_LOAD;
            w_idx_n   = (r_idx == LP_LAST) ? r_idx : r_idx + 5'd1;
         end
         S_RUN: if (flt_out_valid) begin
            // a pulse always clears the watchdog, so completion beats expiry
            w_pix_n   = (r_pix == LP_PIX) ? r_pix : r_pix + 15'd1;
            w_wdog_n  = '0;
            w_state_n = (w_pix_n == LP_PIX) ? S_DONE : S_RUN;
         end else begin
            w_wdog_n  = r_wdog + 16'd1;
            w_state_n = (w_wdog_n == LP_TO) ? S_ERR : S_RUN;
            w_err_n   = (w_wdog_n == LP_TO) || r_err;
         end
         default: w_state_n = S_IDLE;
      endcase
      if (abort && r_state != S_IDLE) begin
         w_state_n = S_IDLE;
         w_pix_n   = r_pix;
         w_wdog_n  = r_wdog;
         w_err_n   = r_err;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_prime <= '0;
         r_wdog  <= '0;
         r_pix   <= '0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_start <= 1'b0;
         r_fcv   <= 1'b0;
         r_fc    <= '0;
         for (int i = 0; i < NUM_COEF; i++) r_coef[i] <= '0;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_prime <= w_prime_n;
         r_wdog  <= w_wdog_n;
         r_pix   <= w_pix_n;
         r_err   <= w_err_n;
         r_busy  <= (w_state_n == S_PRIME) || (w_state_n == S_LOAD) || (w_state_n == S_RUN);
         r_done  <= (w_state_n == S_DONE);
         r_start <= (w_state_n == S_PRIME) || (w_state_n == S_LOAD);
         r_fcv   <= (w_state_n == S_LOAD);
         r_fc    <= (w_state_n == S_LOAD) ? r_coef[w_idx_n] : '0;
         if (w_we) r_coef[cfg_addr] <= cfg_data;
      end
   end
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;
   assign pix_count    = r_pix;
   assign flt_start    = r_start;
   assign flt_fc_valid = r_fcv;
   assign flt_fc       = r_fc;
endmodule
